// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//
// Round-robin write arbiter in front of the write side of an async FIFO. Each of
// NUM_SRC sources presents a stream of words framed by src_last. One source is
// granted per packet. The arbiter writes a header word that identifies the source,
// then passes the granted source's payload straight through to the FIFO until
// src_last or until MAX_PKT_WORDS beats have been accepted. A packet cut off by the
// beat limit is counted as truncated, and the source's remaining words go out later
// as a new packet under a fresh grant.
//
// Ports
//   wr_clk        in   1                  FIFO write-domain clock, rising edge
//   reset         in   1                  synchronous, active-high
//   src_valid     in   NUM_SRC            per-source word valid
//   src_data      in   NUM_SRC*DATA_LEN   source i at [i*DATA_LEN +: DATA_LEN]
//   src_last      in   NUM_SRC            final payload word of a packet
//   src_ready     out  NUM_SRC            word accepted when valid is also high
//   fifo_full     in   1                  FIFO write-side full flag
//   fifo_write_en out  1                  FIFO write strobe
//   fifo_data     out  DATA_LEN           FIFO write word
//   busy          out  1                  high whenever not idle
//   grant_id      out  ID_W               current / most recent grant
//   pkt_count     out  16                 completed packets, saturating
//   trunc_count   out  16                 truncated packets, saturating

module fifo_wr_arbiter #(
   parameter int unsigned DATA_LEN      = 16,
   parameter int unsigned NUM_SRC       = 4,
   parameter int unsigned MAX_PKT_WORDS = 256,
   localparam int unsigned ID_W         = $clog2(NUM_SRC)
) (
   input  logic                         wr_clk,
   input  logic                         reset,
   input  logic [NUM_SRC-1:0]           src_valid,
   input  logic [NUM_SRC*DATA_LEN-1:0]  src_data,
   input  logic [NUM_SRC-1:0]           src_last,
   output logic [NUM_SRC-1:0]           src_ready,
   input  logic                         fifo_full,
   output logic                         fifo_write_en,
   output logic [DATA_LEN-1:0]          fifo_data,
   output logic                         busy,
   output logic [ID_W-1:0]              grant_id,
   output logic [15:0]                  pkt_count,
   output logic [15:0]                  trunc_count
);

   // The beat counter must be able to hold MAX_PKT_WORDS itself, and is never
   // narrower than 9 bits.
   localparam int unsigned BEAT_MIN_W = $clog2(MAX_PKT_WORDS + 1);
   localparam int unsigned BEAT_W     = (BEAT_MIN_W > 9) ? BEAT_MIN_W : 9;

   typedef enum logic [1:0] {
      StIdle,
      StHeader,
      StStream
   } state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [15:0]         pkt_count_q, pkt_count_d;
   logic [15:0]         trunc_count_q, trunc_count_d;

   // ---------------------------------------------------------------------------
   // Round-robin search: first valid source strictly after rr_ptr, wrapping.
   // rr_ptr itself is examined last, so a lone requester is re-granted.
   // ---------------------------------------------------------------------------
   logic              arb_found;
   logic [ID_W-1:0]   arb_idx;
   logic [31:0]       cand;
   logic [ID_W-1:0]   cand_id;

   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      cand_id   = '0;
      for (int unsigned off = 1; off <= NUM_SRC; off++) begin
         cand = off + 32'(rr_ptr_q);
         if (cand >= NUM_SRC) begin
            cand = cand - NUM_SRC;
         end
         cand_id = cand[ID_W-1:0];
         if (!arb_found && src_valid[cand_id]) begin
            arb_found = 1'b1;
            arb_idx   = cand_id;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Granted-source view. Only the granted slice reaches the outputs, so the
   // other sources' inputs cannot disturb anything.
   // ---------------------------------------------------------------------------
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_LEN-1:0]   sel_data;
   logic [DATA_LEN-1:0]   header_word;
   logic [BEAT_W-1:0]     beat_next;
   logic                  beat_at_limit;

   always_comb begin
      sel_valid = src_valid[grant_id_q];
      sel_last  = src_last[grant_id_q];
      sel_data  = src_data[grant_id_q*DATA_LEN +: DATA_LEN];
   end

   // Header: MSB flags a header, low bits carry the source ID.
   always_comb begin
      header_word                = '0;
      header_word[DATA_LEN-1]    = 1'b1;
      header_word[ID_W-1:0]      = grant_id_q;
   end

   assign beat_next     = beat_cnt_q + 1'b1;
   assign beat_at_limit = (beat_next == BEAT_W'(MAX_PKT_WORDS));

   // ---------------------------------------------------------------------------
   // FSM next-state and outputs
   // ---------------------------------------------------------------------------
   logic                  pkt_inc;
   logic                  trunc_inc;
   logic [NUM_SRC-1:0]    ready_raw;
   logic                  write_raw;
   logic [DATA_LEN-1:0]   data_raw;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      beat_cnt_d = beat_cnt_q;
      pkt_inc    = 1'b0;
      trunc_inc  = 1'b0;
      ready_raw  = '0;
      write_raw  = 1'b0;
      data_raw   = '0;

      unique case (state_q)
         StIdle: begin
            if (arb_found) begin
               grant_id_d = arb_idx;
               rr_ptr_d   = arb_idx;
               state_d    = StHeader;
            end
         end

         StHeader: begin
            write_raw = !fifo_full;
            data_raw  = header_word;
            if (!fifo_full) begin
               beat_cnt_d = '0;
               state_d    = StStream;
            end
         end

         StStream: begin
            ready_raw[grant_id_q] = !fifo_full;
            write_raw             = sel_valid && !fifo_full;
            data_raw              = sel_data;
            if (sel_valid && !fifo_full) begin
               beat_cnt_d = beat_next;
               // src_last wins when it lands on the limit beat.
               if (sel_last) begin
                  pkt_inc = 1'b1;
                  state_d = StIdle;
               end else if (beat_at_limit) begin
                  trunc_inc = 1'b1;
                  state_d   = StIdle;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Saturating event counters.
   always_comb begin
      pkt_count_d   = pkt_count_q;
      trunc_count_d = trunc_count_q;
      if (pkt_inc && (pkt_count_q != 16'hFFFF)) begin
         pkt_count_d = pkt_count_q + 16'd1;
      end
      if (trunc_inc && (trunc_count_q != 16'hFFFF)) begin
         trunc_count_d = trunc_count_q + 16'd1;
      end
   end

   // Strobes are masked while reset is high so an interrupted packet stops
   // immediately, before the state register has been cleared.
   always_comb begin
      src_ready     = reset ? '0 : ready_raw;
      fifo_write_en = write_raw && !reset;
      fifo_data     = data_raw;
      busy          = (state_q != StIdle) && !reset;
      grant_id      = grant_id_q;
      pkt_count     = pkt_count_q;
      trunc_count   = trunc_count_q;
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge wr_clk) begin
      if (reset) begin
         state_q       <= StIdle;
         rr_ptr_q      <= ID_W'(NUM_SRC - 1);
         grant_id_q    <= '0;
         beat_cnt_q    <= '0;
         pkt_count_q   <= '0;
         trunc_count_q <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_id_q    <= grant_id_d;
         beat_cnt_q    <= beat_cnt_d;
         pkt_count_q   <= pkt_count_d;
         trunc_count_q <= trunc_count_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter (DATA_LEN=16, NUM_SRC=4, MAX_PKT_WORDS=256).
// A cycle-by-cycle vector table covers grant, header, stream, stall and reset
// behaviour; queue-driven sources then cover multi-packet sequences.

module tb_fifo_wr_arbiter;

   logic          wr_clk = 1'b0;
   logic          reset;
   logic [3:0]    src_valid;
   logic [63:0]   src_data;
   logic [3:0]    src_last;
   logic [3:0]    src_ready;
   logic          fifo_full;
   logic          fifo_write_en;
   logic [15:0]   fifo_data;
   logic          busy;
   logic [1:0]    grant_id;
   logic [15:0]   pkt_count;
   logic [15:0]   trunc_count;

   fifo_wr_arbiter #(
      .DATA_LEN      (16),
      .NUM_SRC       (4),
      .MAX_PKT_WORDS (256)
   ) dut (
      .wr_clk        (wr_clk),
      .reset         (reset),
      .src_valid     (src_valid),
      .src_data      (src_data),
      .src_last      (src_last),
      .src_ready     (src_ready),
      .fifo_full     (fifo_full),
      .fifo_write_en (fifo_write_en),
      .fifo_data     (fifo_data),
      .busy          (busy),
      .grant_id      (grant_id),
      .pkt_count     (pkt_count),
      .trunc_count   (trunc_count)
   );

   always #5 wr_clk = ~wr_clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Vector table
   // ---------------------------------------------------------------------------
   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [3:0]  last;
      logic        full;
      logic        we;
      logic [3:0]  ready;
      logic        busy;
      logic [1:0]  grant;
      logic [15:0] data;
      logic [15:0] pkt;
      logic [15:0] trunc;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic rst, input logic [3:0] v, input logic [3:0] l,
                      input logic f, input logic we, input logic [3:0] rdy, input logic b,
                      input logic [1:0] g, input logic [15:0] d, input logic [15:0] p,
                      input logic [15:0] t);
      vec_t r;
      r.rst = rst; r.valid = v; r.last = l; r.full = f; r.we = we; r.ready = rdy;
      r.busy = b; r.grant = g; r.data = d; r.pkt = p; r.trunc = t;
      tv.push_back(r);
   endtask

   // ---------------------------------------------------------------------------
   // Queue-driven source model and write capture
   // ---------------------------------------------------------------------------
   logic [16:0]  srcq[4][$];   // {last, data}
   logic [3:0]   src_en;
   logic         full_sched;
   logic [15:0]  cap[$];
   int           cap_t[$];
   logic [15:0]  expq[$];
   int           cyc;
   int           viol;

   function automatic logic [15:0] cap_at(input int k);
      if (k < cap.size()) return cap[k];
      return 16'hDEAD;
   endfunction

   function automatic int stamp_at(input int k);
      if (k < cap_t.size()) return cap_t[k];
      return -1;
   endfunction

   function automatic logic all_empty();
      for (int i = 0; i < 4; i++) begin
         if (srcq[i].size() != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Entered on a negedge; drives, samples at +1, pops accepted words, steps to
   // the next negedge.
   task automatic cycle();
      for (int i = 0; i < 4; i++) begin
         src_valid[i] = src_en[i] && (srcq[i].size() > 0);
         if (srcq[i].size() > 0) begin
            src_data[i*16 +: 16] = srcq[i][0][15:0];
            src_last[i]          = srcq[i][0][16];
         end else begin
            src_data[i*16 +: 16] = 16'h0;
            src_last[i]          = 1'b0;
         end
      end
      fifo_full = full_sched;
      #1;
      if (fifo_full && (fifo_write_en || (src_ready != 4'h0))) viol++;
      if (reset && (fifo_write_en || (src_ready != 4'h0) || busy)) viol++;
      if (fifo_write_en) begin
         cap.push_back(fifo_data);
         cap_t.push_back(cyc);
      end
      for (int i = 0; i < 4; i++) begin
         if (src_ready[i] && src_valid[i]) void'(srcq[i].pop_front());
      end
      @(posedge wr_clk);
      cyc++;
      @(negedge wr_clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) srcq[i].delete();
      src_en     = 4'hF;
      full_sched = 1'b0;
      cycle();
      cycle();
      reset = 1'b0;
      cap.delete();
      cap_t.delete();
      expq.delete();
      cyc  = 0;
      viol = 0;
   endtask

   task automatic push_pkt(input int src, input int base, input int n);
      for (int w = 0; w < n; w++) begin
         srcq[src].push_back({(w == n - 1), 16'(base + w)});
      end
   endtask

   task automatic run_until_idle(input string name, input int limit);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (!(all_empty() && !busy) && (n < limit));
      chk({name, " finished"}, 32'(all_empty() && !busy), 32'd1);
   endtask

   task automatic chk_cap(input string name);
      chk({name, " word count"}, cap.size(), expq.size());
      for (int k = 0; k < expq.size(); k++) begin
         chk($sformatf("%s word%0d", name, k), cap_at(k), expq[k]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      src_valid = '0;
      src_last  = '0;
      src_data  = '0;
      fifo_full = 1'b0;
      src_en    = 4'hF;
      full_sched = 1'b0;
      cyc  = 0;
      viol = 0;

      //   rst valid last full | we  rdy  busy grant data      pkt  trunc
      add(1, 4'h0, 4'h0, 0,    0, 4'h0, 0, 2'd0, 16'h0000, 16'd0, 16'd0);
      add(1, 4'h0, 4'h0, 0,    0, 4'h0, 0, 2'd0, 16'h0000, 16'd0, 16'd0);
      add(0, 4'h0, 4'h0, 0,    0, 4'h0, 0, 2'd0, 16'h0000, 16'd0, 16'd0);
      add(0, 4'hA, 4'h0, 0,    0, 4'h0, 0, 2'd0, 16'h0000, 16'd0, 16'd0);
      add(0, 4'hA, 4'h0, 0,    1, 4'h0, 1, 2'd1, 16'h8001, 16'd0, 16'd0);
      add(0, 4'hA, 4'h0, 0,    1, 4'h2, 1, 2'd1, 16'h2221, 16'd0, 16'd0);
      add(0, 4'hA, 4'h2, 0,    1, 4'h2, 1, 2'd1, 16'h2221, 16'd0, 16'd0);
      add(0, 4'hA, 4'h0, 0,    0, 4'h0, 0, 2'd1, 16'h0000, 16'd1, 16'd0);
      add(0, 4'hA, 4'h0, 1,    0, 4'h0, 1, 2'd3, 16'h0000, 16'd1, 16'd0);
      add(0, 4'hA, 4'h0, 0,    1, 4'h0, 1, 2'd3, 16'h8003, 16'd1, 16'd0);
      add(0, 4'h2, 4'h0, 0,    0, 4'h8, 1, 2'd3, 16'h0000, 16'd1, 16'd0);
      add(0, 4'hA, 4'h0, 1,    0, 4'h0, 1, 2'd3, 16'h0000, 16'd1, 16'd0);
      add(0, 4'h8, 4'h8, 0,    1, 4'h8, 1, 2'd3, 16'h4443, 16'd1, 16'd0);
      add(0, 4'h0, 4'h0, 0,    0, 4'h0, 0, 2'd3, 16'h0000, 16'd2, 16'd0);
      add(0, 4'h1, 4'h0, 0,    0, 4'h0, 0, 2'd3, 16'h0000, 16'd2, 16'd0);
      add(0, 4'h1, 4'h0, 0,    1, 4'h0, 1, 2'd0, 16'h8000, 16'd2, 16'd0);
      add(0, 4'h1, 4'h0, 0,    1, 4'h1, 1, 2'd0, 16'h1110, 16'd2, 16'd0);
      add(1, 4'h1, 4'h0, 0,    0, 4'h0, 0, 2'd0, 16'h0000, 16'd2, 16'd0);
      add(0, 4'hF, 4'h0, 0,    0, 4'h0, 0, 2'd0, 16'h0000, 16'd0, 16'd0);
      add(0, 4'hF, 4'h0, 0,    1, 4'h0, 1, 2'd0, 16'h8000, 16'd0, 16'd0);

      @(negedge wr_clk);
      for (int k = 0; k < tv.size(); k++) begin
         reset     = tv[k].rst;
         src_valid = tv[k].valid;
         src_last  = tv[k].last;
         fifo_full = tv[k].full;
         src_data  = 64'h4443_3332_2221_1110;
         #1;
         chk($sformatf("row%0d write_en", k), 32'(fifo_write_en), 32'(tv[k].we));
         chk($sformatf("row%0d src_ready", k), 32'(src_ready), 32'(tv[k].ready));
         chk($sformatf("row%0d busy", k), 32'(busy), 32'(tv[k].busy));
         chk($sformatf("row%0d grant_id", k), 32'(grant_id), 32'(tv[k].grant));
         chk($sformatf("row%0d pkt_count", k), 32'(pkt_count), 32'(tv[k].pkt));
         chk($sformatf("row%0d trunc_count", k), 32'(trunc_count), 32'(tv[k].trunc));
         if (tv[k].we) begin
            chk($sformatf("row%0d fifo_data", k), 32'(fifo_data), 32'(tv[k].data));
         end
         @(posedge wr_clk);
         @(negedge wr_clk);
      end

      // Two simultaneous 2-word packets from sources 1 and 3.
      do_reset();
      push_pkt(1, 16'h1A00, 2);
      push_pkt(3, 16'h3A00, 2);
      run_until_idle("pair", 50);
      expq = '{16'h8001, 16'h1A00, 16'h1A01, 16'h8003, 16'h3A00, 16'h3A01};
      chk_cap("pair");
      chk("pair pkt_count", 32'(pkt_count), 32'd2);

      // All sources continuously valid, one-word packets: round-robin, 3 cycles each.
      do_reset();
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 4; i++) push_pkt(i, 16'h1000 * (i + 1) + p, 1);
      end
      run_until_idle("rr", 60);
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 4; i++) begin
            expq.push_back(16'h8000 | 16'(i));
            expq.push_back(16'(16'h1000 * (i + 1) + p));
         end
      end
      chk_cap("rr");
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("rr header%0d cycle", k), 32'(stamp_at(2 * k)), 32'(3 * k + 1));
         chk($sformatf("rr beat%0d cycle", k), 32'(stamp_at(2 * k + 1)), 32'(3 * k + 2));
      end
      chk("rr pkt_count", 32'(pkt_count), 32'd8);

      // FIFO full for 5 cycles in HEADER and 5 cycles mid-STREAM.
      do_reset();
      push_pkt(0, 16'h0C00, 4);
      for (int c = 0; c < 20; c++) begin
         full_sched = ((c >= 1) && (c <= 5)) || ((c >= 9) && (c <= 13));
         cycle();
      end
      full_sched = 1'b0;
      expq = '{16'h8000, 16'h0C00, 16'h0C01, 16'h0C02, 16'h0C03};
      chk_cap("stall");
      chk("stall header cycle", 32'(stamp_at(0)), 32'd6);
      chk("stall beat0 cycle", 32'(stamp_at(1)), 32'd7);
      chk("stall beat1 cycle", 32'(stamp_at(2)), 32'd8);
      chk("stall beat2 cycle", 32'(stamp_at(3)), 32'd14);
      chk("stall beat3 cycle", 32'(stamp_at(4)), 32'd15);
      chk("stall no strobe while full", 32'(viol), 32'd0);

      // 300-word packet truncated at 256 beats.
      do_reset();
      push_pkt(2, 16'h2000, 300);
      run_until_idle("trunc", 1000);
      expq.push_back(16'h8002);
      for (int w = 0; w < 256; w++) expq.push_back(16'(16'h2000 + w));
      expq.push_back(16'h8002);
      for (int w = 256; w < 300; w++) expq.push_back(16'(16'h2000 + w));
      chk_cap("trunc");
      chk("trunc trunc_count", 32'(trunc_count), 32'd1);
      chk("trunc pkt_count", 32'(pkt_count), 32'd1);

      // src_last on exactly the 256th beat is a normal completion.
      do_reset();
      push_pkt(1, 16'h5000, 256);
      run_until_idle("limit", 1000);
      chk("limit word count", cap.size(), 32'd257);
      chk("limit final word", 32'(cap_at(256)), 32'h50FF);
      chk("limit pkt_count", 32'(pkt_count), 32'd1);
      chk("limit trunc_count", 32'(trunc_count), 32'd0);

      // Reset after 3 beats of a 10-word packet.
      do_reset();
      for (int i = 0; i < 4; i++) push_pkt(i, 16'h1000 * (i + 1), 10);
      begin
         int n = 0;
         while ((cap.size() < 4) && (n < 20)) begin
            cycle();
            n++;
         end
      end
      chk("rst pre-reset writes", cap.size(), 32'd4);
      chk("rst first header", 32'(cap_at(0)), 32'h8000);
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      chk("rst no writes during reset", cap.size(), 32'd4);
      chk("rst pkt_count", 32'(pkt_count), 32'd0);
      chk("rst trunc_count", 32'(trunc_count), 32'd0);
      begin
         int n = 0;
         while ((cap.size() < 5) && (n < 10)) begin
            cycle();
            n++;
         end
      end
      chk("rst next header", 32'(cap_at(4)), 32'h8000);
      chk("rst grant_id", 32'(grant_id), 32'd0);
      chk("rst invariants", 32'(viol), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_LEN, default 16, SHALL set the width of source and FIFO data words.
REQ-002 Parameter NUM_SRC, default 4, SHALL set the number of requesters (range 2..16).
REQ-003 Parameter MAX_PKT_WORDS, default 256, SHALL set the maximum payload beats per granted packet.
REQ-004 Derived ID_W = $clog2(NUM_SRC) SHALL be the source-ID width.
REQ-005 wr_clk  input  1  SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  SHALL be synchronous, active-high.
REQ-007 src_valid  input  NUM_SRC  SHALL be the per-source word-valid flags.
REQ-008 src_data  input  NUM_SRC*DATA_LEN  SHALL carry the per-source words; source i occupies bits [i*DATA_LEN +: DATA_LEN].
REQ-009 src_last  input  NUM_SRC  SHALL mark a source's final payload word of a packet.
REQ-010 src_ready  output  NUM_SRC  SHALL indicate that a source word is accepted this cycle when its valid is also high.
REQ-011 fifo_full  input  1  SHALL be the write-side full flag of the downstream async FIFO.
REQ-012 fifo_write_en  output  1  SHALL be the FIFO write strobe.
REQ-013 fifo_data  output  DATA_LEN  SHALL be the FIFO write word.
REQ-014 busy  output  1  SHALL be high in any state other than IDLE.
REQ-015 grant_id  output  ID_W  SHALL be the currently or most recently granted source.
REQ-016 pkt_count  output  16  SHALL count completed packets, saturating at 0xFFFF.
REQ-017 trunc_count  output  16  SHALL count truncated packets, saturating at 0xFFFF.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, HEADER, STREAM.
REQ-019 In IDLE with any src_valid high, the block SHALL grant the first valid source searching upward from rr_ptr+1 modulo NUM_SRC, latch grant_id, set rr_ptr to that source, and enter HEADER next cycle.
REQ-020 In IDLE with no src_valid high, the FSM SHALL remain in IDLE, hold rr_ptr and assert no strobe.
REQ-021 In HEADER, fifo_write_en SHALL equal !fifo_full, and fifo_data SHALL be bit DATA_LEN-1 = 1, bits [ID_W-1:0] = grant_id, all other bits 0.
REQ-022 The FSM SHALL leave HEADER for STREAM only on a cycle where the header is written; otherwise it SHALL stay in HEADER.
REQ-023 In STREAM, src_ready[grant_id] SHALL equal !fifo_full, and all other src_ready bits SHALL be 0.
REQ-024 In STREAM, fifo_write_en SHALL equal src_valid[grant_id] && !fifo_full, and fifo_data SHALL equal src_data of grant_id, passed through combinationally with zero cycle latency.
REQ-025 In IDLE and HEADER, all src_ready bits SHALL be 0.
REQ-026 A 9-bit-or-wider beat counter SHALL clear on entry to STREAM and increment on each accepted payload beat.
REQ-027 An accepted beat with src_last high SHALL increment pkt_count and return the FSM to IDLE.
REQ-028 An accepted beat that is the MAX_PKT_WORDS-th beat with src_last low SHALL end the packet, increment trunc_count (not pkt_count), and return the FSM to IDLE; the source's remaining words SHALL form a new packet under a later grant.
REQ-029 When the MAX_PKT_WORDS-th beat also carries src_last, it SHALL count as a normal completion only.
REQ-030 Grants SHALL be held for a whole packet regardless of other requesters; a deasserted src_valid mid-packet SHALL stall STREAM, not end it.
REQ-031 Changes to non-granted source inputs SHALL have no effect on outputs.
REQ-032 fifo_write_en SHALL never be high while fifo_full is high.
REQ-033 Per-packet overhead SHALL be exactly one IDLE cycle plus one header cycle when unstalled.

Reset
REQ-034 While reset is high: state = IDLE, rr_ptr = NUM_SRC-1, grant_id = 0, beat counter = 0, pkt_count = 0, trunc_count = 0.
REQ-035 While reset is high: src_ready = 0, fifo_write_en = 0, busy = 0.
REQ-036 Reset asserted mid-packet SHALL abandon the packet with no further writes and no counter update.

Verification
REQ-037 After reset, sources 1 and 3 each send 2-word packets (last on word 2) simultaneously -> FIFO receives 0x8001, s1w0, s1w1, 0x8003, s3w0, s3w1; pkt_count = 2.
REQ-038 All 4 sources continuously valid for 8 one-word packets -> grant order 0,1,2,3,0,1,2,3; each packet takes 3 cycles.
REQ-039 fifo_full held high for 5 cycles during HEADER and again mid-STREAM -> fifo_write_en = 0 and src_ready = 0 throughout both stalls; no word lost or duplicated.
REQ-040 Source 2 sends 300 words with last only on word 300 (MAX_PKT_WORDS = 256) -> 0x8002 + 256 words, trunc_count = 1, then 0x8002 + 44 words, pkt_count = 1.
REQ-041 Reset pulsed after 3 payload beats of a 10-word packet -> no writes after reset, counters = 0, next grant goes to source 0 when all sources are valid.
